fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch sequencer. Requests one word at a time from
//                instruction memory, issues it to the decoder and advances the
//                PC (sequential or taken branch), stopping on the halt opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instruction,
    output logic        instrValid,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branchOffset,
    output logic [31:0] pc,
    output logic        halted
);

    localparam logic [6:0] c_halt_opcode = 7'd127;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_pc_sum;
    logic [31:0] w_next_pc;
    logic        w_capture;
    logic        w_consume;
    logic        w_is_halt;

    assign w_capture = (r_state == S_REQ) && imemAck;
    assign w_consume = (r_state == S_ISSUE) && !stall;
    assign w_is_halt = (r_instr[6:0] == c_halt_opcode);

    // Offset is applied modulo 2^32, then the low bits are cleared to keep
    // the PC word-aligned even for odd branch offsets.
    assign w_pc_sum  = r_pc + ((branch && zero) ? branchOffset : 32'd4);
    assign w_next_pc = {w_pc_sum[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_REQ;
            S_REQ:   if (imemAck) w_next_state = S_ISSUE;
            S_ISSUE: if (!stall) w_next_state = w_is_halt ? S_HALT : S_REQ;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
        end else begin
            if (w_capture) begin
                r_instr <= imemData;
            end
            if (w_consume && !w_is_halt) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign imemReq     = (r_state == S_REQ);
    assign imemAddr    = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign instrValid  = (r_state == S_ISSUE);
    assign halted      = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                randomized traffic against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branchOffset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] pc;
    logic        halted;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    fetch_unit #(.RESET_PC(c_reset_pc)) dut (
        .clk          (clk),
        .reset        (reset),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instruction  (instruction),
        .instrValid   (instrValid),
        .stall        (stall),
        .branch       (branch),
        .zero         (zero),
        .branchOffset (branchOffset),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: which phase the fetcher is in, the PC and the held word.
    localparam int M_IDLE = 0, M_REQ = 1, M_ISSUE = 2, M_HALT = 3;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_word;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_pc    = c_reset_pc;
        m_word  = 32'h0;
    endtask

    task automatic check_all();
        check("imemReq",     32'(imemReq),    32'(m_phase == M_REQ));
        check("instrValid",  32'(instrValid), 32'(m_phase == M_ISSUE));
        check("halted",      32'(halted),     32'(m_phase == M_HALT));
        check("pc",          pc,              m_pc);
        check("imemAddr",    imemAddr,        m_pc);
        check("instruction", instruction,     m_word);
    endtask

    // One clock: predict from inputs present before the edge, then compare.
    task automatic cycle();
        int          n_phase = m_phase;
        logic [31:0] n_pc    = m_pc;
        logic [31:0] n_word  = m_word;
        case (m_phase)
            M_IDLE: n_phase = M_REQ;
            M_REQ: if (imemAck) begin
                n_word  = imemData;
                n_phase = M_ISSUE;
            end
            M_ISSUE: if (!stall) begin
                if (m_word[6:0] == 7'd127) begin
                    n_phase = M_HALT;
                end else begin
                    n_phase = M_REQ;
                    n_pc = (m_pc + ((branch && zero) ? branchOffset : 32'd4)) & 32'hFFFF_FFFC;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        m_phase = n_phase;
        m_pc    = n_pc;
        m_word  = n_word;
        check_all();
    endtask

    // Asynchronous reset: checked before any clock edge, then held over one edge.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        reset = 1'b0;
    endtask

    // Called with the model in REQ and imemAck high: fetch, then consume.
    task automatic fetch_consume(input logic [31:0] word, input logic br, input logic z,
                                 input logic [31:0] off);
        imemAck  = 1'b1;
        imemData = word;
        stall    = 1'b0;
        cycle();
        branch       = br;
        zero         = z;
        branchOffset = off;
        cycle();
        branch = 1'b0;
        zero   = 1'b0;
    endtask

    logic [31:0] held_pc;
    logic [31:0] held_word;
    int          halt_cycles;

    initial begin
        reset = 1'b0; imemAck = 1'b0; imemData = 32'h0; stall = 1'b0;
        branch = 1'b0; zero = 1'b0; branchOffset = 32'h0;
        model_reset();
        #3;
        do_reset();

        // Streaming with immediate ack: addresses 0,4,8,12.
        imemAck = 1'b1; imemData = 32'h0000_0033;
        cycle();
        for (int k = 0; k < 4; k++) begin
            check("seq_addr", imemAddr, 32'(4 * k));
            check("seq_req", 32'(imemReq), 32'd1);
            cycle();
            check("seq_valid", 32'(instrValid), 32'd1);
            cycle();
        end

        // Branch taken / not taken from pc=16.
        check("br_start_pc", pc, 32'd16);
        fetch_consume(32'h0000_0063, 1'b1, 1'b1, 32'hFFFF_FFF8);
        check("br_taken_pc", pc, 32'd8);
        fetch_consume(32'h0000_0033, 1'b0, 1'b0, 32'h0);
        fetch_consume(32'h0000_0033, 1'b0, 1'b0, 32'h0);
        fetch_consume(32'h0000_0063, 1'b1, 1'b0, 32'hFFFF_FFF8);
        check("br_not_taken_pc", pc, 32'd20);

        // Stall for three cycles in ISSUE; branch inputs must be ignored meanwhile.
        imemData = 32'h0000_0013;
        cycle();
        held_pc = pc;
        stall = 1'b1; branch = 1'b1; zero = 1'b1; branchOffset = 32'h100;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_valid", 32'(instrValid), 32'd1);
            check("stall_word", instruction, 32'h0000_0013);
            check("stall_pc", pc, held_pc);
            check("stall_req", 32'(imemReq), 32'd0);
        end
        stall = 1'b0; branch = 1'b0; zero = 1'b0;
        cycle();
        check("stall_release_pc", pc, held_pc + 32'd4);

        // Wait states, then an ack pulse during ISSUE that must not capture.
        imemAck = 1'b0; imemData = 32'hDEAD_BE33;
        held_pc = pc;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("wait_addr", imemAddr, held_pc);
        end
        imemAck = 1'b1; imemData = 32'h1234_5633;
        cycle();
        stall = 1'b1; imemData = 32'hCAFE_F00D;
        cycle();
        check("issue_ack_nocap", instruction, 32'h1234_5633);
        stall = 1'b0; imemAck = 1'b0;
        cycle();
        imemAck = 1'b1;

        // Wrap at the top of the address space and alignment of odd offsets.
        fetch_consume(32'h0000_0063, 1'b1, 1'b1, 32'hFFFF_FFFC - pc);
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        fetch_consume(32'h0000_0033, 1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        fetch_consume(32'h0000_0063, 1'b1, 1'b1, 32'd6);
        check("align_pc", pc, 32'd4);

        // Halt opcode: frozen until reset.
        fetch_consume(32'h0000_007F, 1'b1, 1'b1, 32'h40);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_req", 32'(imemReq), 32'd0);
            check("halt_pc", pc, 32'd4);
        end
        #2;
        do_reset();
        check("halt_reset_pc", pc, c_reset_pc);
        check("halt_reset_flag", 32'(halted), 32'd0);

        // Randomized traffic, with occasional mid-cycle resets.
        halt_cycles = 0;
        for (int k = 0; k < 4000; k++) begin
            imemAck      = ($urandom_range(0, 9) < 7);
            imemData     = $urandom;
            if ($urandom_range(0, 24) == 0) imemData[6:0] = 7'd127;
            else if (imemData[6:0] == 7'd127) imemData[6:0] = 7'h33;
            stall        = ($urandom_range(0, 3) == 0);
            branch       = $urandom_range(0, 1) == 1;
            zero         = $urandom_range(0, 1) == 1;
            branchOffset = $urandom_range(0, 1) == 1 ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            halt_cycles  = (m_phase == M_HALT) ? halt_cycles + 1 : 0;
            if (halt_cycles > 4 || $urandom_range(0, 199) == 0) begin
                #($urandom_range(1, 3));
                do_reset();
                halt_cycles = 0;
            end else begin
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
